// File: rtl/seq_mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// State encodings and the counter-width helper.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// Datapath of seq_mult: operand magnitudes, shifters,
// accumulator and sign fix-up of the registered product.
module seq_mult_dp
  import seq_mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_finish,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_p
);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_p;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_acc_nxt;

  // -2^(WIDTH-1) negates to itself, which read unsigned is its magnitude
  assign w_a_neg = (SIGNED != 0) && i_a[WIDTH-1];
  assign w_b_neg = (SIGNED != 0) && i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~i_a + 1'b1) : i_a;
  assign w_b_mag = w_b_neg ? (~i_b + 1'b1) : i_b;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_p      <= '0;
    end else begin
      if (i_load) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
        r_mplier <= w_b_mag;
        r_acc    <= '0;
        r_neg    <= w_a_neg ^ w_b_neg;
      end else if (i_step) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
      if (i_finish)
        r_p <= r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier with start/done handshake.
// Control FSM and iteration counter; arithmetic lives in seq_mult_dp.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_p
);

  localparam int CW = cnt_w(WIDTH);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            w_load;
  logic            w_step;
  logic            w_finish;
  logic            w_last;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_load)
        r_cnt <= '0;
      else if (w_step)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_load = 1'b1;
          w_next = ST_CALC;
        end
      end
      ST_CALC: begin
        w_step = 1'b1;
        if (w_last) begin
          w_finish = 1'b1;
          w_next   = ST_DONE;
        end
      end
      ST_DONE: begin
        // a start here chains straight into the next operation
        if (i_start) begin
          w_load = 1'b1;
          w_next = ST_CALC;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign o_busy = (r_state == ST_CALC);
  assign o_done = (r_state == ST_DONE);

  seq_mult_dp #(
    .WIDTH (WIDTH),
    .SIGNED(SIGNED)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_finish(w_finish),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_p     (o_p)
  );

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: four instances (3u, 4s, 8u, 8s)
// checked against an arithmetic reference product.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  int          sel;

  logic [3:0]  bs;
  logic [3:0]  dn;
  logic [5:0]  p0;
  logic [7:0]  p1;
  logic [15:0] p2;
  logic [15:0] p3;

  logic        bm;
  logic        dm;
  logic [15:0] pm;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(3), .SIGNED(0)) u_w3u (
    .clk(clk), .rst(rst), .i_start(start && sel == 0),
    .i_a(a[2:0]), .i_b(b[2:0]),
    .o_busy(bs[0]), .o_done(dn[0]), .o_p(p0));

  seq_mult #(.WIDTH(4), .SIGNED(1)) u_w4s (
    .clk(clk), .rst(rst), .i_start(start && sel == 1),
    .i_a(a[3:0]), .i_b(b[3:0]),
    .o_busy(bs[1]), .o_done(dn[1]), .o_p(p1));

  seq_mult #(.WIDTH(8), .SIGNED(0)) u_w8u (
    .clk(clk), .rst(rst), .i_start(start && sel == 2),
    .i_a(a), .i_b(b),
    .o_busy(bs[2]), .o_done(dn[2]), .o_p(p2));

  seq_mult #(.WIDTH(8), .SIGNED(1)) u_w8s (
    .clk(clk), .rst(rst), .i_start(start && sel == 3),
    .i_a(a), .i_b(b),
    .o_busy(bs[3]), .o_done(dn[3]), .o_p(p3));

  always_comb begin
    bm = bs[sel[1:0]];
    dm = dn[sel[1:0]];
    case (sel)
      0:       pm = {10'd0, p0};
      1:       pm = {8'd0, p1};
      2:       pm = p2;
      default: pm = p3;
    endcase
  end

  function automatic int wid(input int s);
    return (s == 0) ? 3 : (s == 1) ? 4 : 8;
  endfunction

  function automatic int sgn(input int s);
    return (s == 1 || s == 3) ? 1 : 0;
  endfunction

  function automatic logic [15:0] ref_p(input int s,
                                        input logic [7:0] x,
                                        input logic [7:0] y);
    int     w;
    longint vx;
    longint vy;
    longint pr;
    w  = wid(s);
    vx = longint'(x) & ((longint'(1) << w) - 1);
    vy = longint'(y) & ((longint'(1) << w) - 1);
    if (sgn(s) != 0 && vx >= (longint'(1) << (w - 1)))
      vx = vx - (longint'(1) << w);
    if (sgn(s) != 0 && vy >= (longint'(1) << (w - 1)))
      vy = vy - (longint'(1) << w);
    pr = vx * vy;
    return 16'(pr & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_chk++;
      assert ((bs & dn) === 4'b0) else begin
        n_fail++;
        $error("FAIL busy_done_excl observed=%b expected=0", bs & dn);
      end
    end
  end

  task automatic wait_done(input logic [15:0] prev, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) check("p_hold", pm, prev);
    end while (dm !== 1'b1 && cnt < 40);
  endtask

  task automatic op(input logic [7:0] ia, input logic [7:0] ib);
    logic [15:0] prev;
    int          c;
    @(negedge clk);
    check("idle_busy", 16'(bm), 16'd0);
    prev  = pm;
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    wait_done(prev, c);
    check("latency", 16'(c), 16'(wid(sel) + 1));
    check("product", pm, ref_p(sel, ia, ib));
  endtask

  initial begin
    int          c;
    int          nd;
    logic [15:0] prev;

    rst   = 1'b1;
    start = 1'b0;
    sel   = 0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      check("rst_busy", 16'(bm), 16'd0);
      check("rst_done", 16'(dm), 16'd0);
      check("rst_p", pm, 16'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    sel = 0;
    op(8'd2, 8'd3);
    op(8'd7, 8'd7);
    op(8'd6, 8'd5);
    op(8'd2, 8'd0);

    // start held high across done: second op follows with no idle cycle
    @(negedge clk);
    prev  = pm;
    a     = 8'd2;
    b     = 8'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'd5;
    b = 8'd4;
    wait_done(prev, c);
    check("b2b_lat1", 16'(c), 16'd4);
    check("b2b_p1", pm, 16'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", 16'(bm), 16'd1);
    wait_done(16'd0, c);
    check("b2b_lat2", 16'(c), 16'd4);
    check("b2b_p2", pm, 16'd20);

    sel = 1;
    op(8'b1101, 8'd5);
    check("s4_neg15", pm, 16'h00F1);
    op(8'b1000, 8'b1000);
    check("s4_min_sq", pm, 16'h0040);
    op(8'd7, 8'b1111);
    check("s4_m7", pm, 16'h00F9);

    // start pulsed again mid-operation must be ignored
    sel = 2;
    @(negedge clk);
    a     = 8'd200;
    b     = 8'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    a     = 8'd1;
    b     = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (dm === 1'b1) nd++;
    end
    check("ign_done_cnt", 16'(nd), 16'd1);
    check("ign_p", pm, 16'd20000);
    check("ign_idle", 16'(bm), 16'd0);

    // asynchronous reset aborts an operation in flight
    sel = 0;
    @(negedge clk);
    a     = 8'd7;
    b     = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 16'(bm), 16'd0);
    check("arst_done", 16'(dm), 16'd0);
    check("arst_p", pm, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (dm === 1'b1) nd++;
    end
    check("arst_no_done", 16'(nd), 16'd0);
    op(8'd3, 8'd3);

    for (int s = 2; s < 4; s++) begin
      sel = s;
      op(8'h80, 8'h80);
      op(8'hFF, 8'h01);
      repeat (1000) op(8'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
